// File: rtl/spi_fsm_pkg.sv
// Shared types and constants for the SPI slave control FSM.
// Optional abort pulse is enabled with SPI_FSM_FRAME_ERR_EN.
package spi_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_HDR,
    S_DECODE,
    S_READ_LOAD,
    S_READ_SHIFT,
    S_WRITE_GET,
    S_WRITE_STORE,
    S_DONE
  } state_t;

  localparam int ADDR_BITS_DEF = 7;
  localparam int DATA_BITS_DEF = 8;

  function automatic int cnt_width(input int a, input int d);
    int m;
    m = (a + 1 > d) ? a + 1 : d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// SCLK edge counter with synchronous clear and terminal-count flag.
// o_tc is high on the edge that completes i_limit counts.
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = i_en && (r_cnt == i_limit - W'(1));

endmodule

// File: rtl/spi_control_fsm.sv
// SPI memory slave control FSM: header decode, read load/shift, write store.
// Define SPI_FSM_FRAME_ERR_EN to add the registered frameErr abort pulse.
module spi_control_fsm
  import spi_fsm_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic sclkPosEdge,
  input  logic csN,
  input  logic shiftRegRW,
  output logic addrLatchEn,
  output logic srLoadEn,
  output logic dmWriteEn,
  output logic misoBufEn
`ifdef SPI_FSM_FRAME_ERR_EN
  ,
  output logic frameErr
`endif
);

  localparam int CW = cnt_width(ADDR_BITS, DATA_BITS);

  state_t          r_state;
  state_t          w_next;
  logic            w_en;
  logic            w_clr;
  logic            w_tc;
  logic [CW-1:0]   w_limit;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  assign w_en = sclkPosEdge &&
                (r_state inside {S_GET_HDR, S_WRITE_GET, S_READ_SHIFT});
  assign w_limit = (r_state == S_GET_HDR) ? CW'(ADDR_BITS + 1)
                                          : CW'(DATA_BITS);
  assign w_clr = (w_next != r_state);

  spi_bit_counter #(.W(CW)) u_cnt (
    .clk     (clk),
    .resetN  (resetN),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next = r_state;
    if (csN && r_state != S_IDLE) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:        if (!csN) w_next = S_GET_HDR;
        S_GET_HDR:     if (w_tc) w_next = S_DECODE;
        S_DECODE:      w_next = shiftRegRW ? S_READ_LOAD : S_WRITE_GET;
        S_READ_LOAD:   w_next = S_READ_SHIFT;
        S_READ_SHIFT:  if (w_tc) w_next = S_DONE;
        S_WRITE_GET:   if (w_tc) w_next = S_WRITE_STORE;
        S_WRITE_STORE: w_next = S_DONE;
        S_DONE:        w_next = S_DONE;
        default:       w_next = S_IDLE;
      endcase
    end
  end

  assign addrLatchEn = (r_state == S_DECODE);
  assign srLoadEn    = (r_state == S_READ_LOAD);
  assign dmWriteEn   = (r_state == S_WRITE_STORE);
  assign misoBufEn   = (r_state == S_READ_LOAD) ||
                       (r_state == S_READ_SHIFT);

`ifdef SPI_FSM_FRAME_ERR_EN
  logic r_frameErr;

  // Fires alongside the forced return to IDLE, so it lasts one clk.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_frameErr <= 1'b0;
    else
      r_frameErr <= csN && (r_state inside {S_GET_HDR, S_DECODE,
                    S_READ_LOAD, S_READ_SHIFT, S_WRITE_GET, S_WRITE_STORE});
  end

  assign frameErr = r_frameErr;
`endif

endmodule

// File: tb/tb_spi_control_fsm.sv
// Directed self-checking bench for spi_control_fsm.
// Build with +define+SPI_FSM_FRAME_ERR_EN to also check frameErr.
module tb_spi_control_fsm;
  import spi_fsm_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  logic sclkPosEdge;
  logic csN;
  logic shiftRegRW;
  logic addrLatchEn;
  logic srLoadEn;
  logic dmWriteEn;
  logic misoBufEn;
  logic w_fe;

  int total = 0;
  int bad = 0;
  int n_al, n_sr, n_wr, n_mi, n_fe;

  always #5 clk = ~clk;

  spi_control_fsm dut (
    .clk         (clk),
    .resetN      (resetN),
    .sclkPosEdge (sclkPosEdge),
    .csN         (csN),
    .shiftRegRW  (shiftRegRW),
    .addrLatchEn (addrLatchEn),
    .srLoadEn    (srLoadEn),
    .dmWriteEn   (dmWriteEn),
    .misoBufEn   (misoBufEn)
`ifdef SPI_FSM_FRAME_ERR_EN
    ,
    .frameErr    (w_fe)
`endif
  );

`ifndef SPI_FSM_FRAME_ERR_EN
  assign w_fe = 1'b0;
`endif

  always @(negedge clk) begin
    n_al += int'(addrLatchEn);
    n_sr += int'(srLoadEn);
    n_wr += int'(dmWriteEn);
    n_mi += int'(misoBufEn);
    n_fe += int'(w_fe);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_al = 0; n_sr = 0; n_wr = 0; n_mi = 0; n_fe = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sclkPosEdge = 1'b1;
      tick();
      sclkPosEdge = 1'b0;
      tick(); tick(); tick();
    end
  endtask

  task automatic start();
    csN = 1'b0;
    tick();
    chk("start_state", int'(dut.r_state), int'(S_GET_HDR));
  endtask

  task automatic hdr(input logic rw);
    shiftRegRW = rw;
    pulses(ADDR_BITS_DEF);
    sclkPosEdge = 1'b1;
    tick();
    chk("al_high", int'(addrLatchEn), 1);
    sclkPosEdge = 1'b0;
    tick();
    chk("al_low", int'(addrLatchEn), 0);
    chk("sr_next", int'(srLoadEn), int'(rw));
    chk("mi_next", int'(misoBufEn), int'(rw));
    tick();
    chk("sr_once", int'(srLoadEn), 0);
    chk("mi_hold", int'(misoBufEn), int'(rw));
    tick();
  endtask

  task automatic end_frame();
    csN = 1'b1;
    tick();
    chk("idle", int'(dut.r_state), int'(S_IDLE));
    tick();
  endtask

  initial begin
    resetN = 1'b0;
    csN = 1'b0;
    sclkPosEdge = 1'b0;
    shiftRegRW = 1'b1;
    clr_cnt();
    for (int i = 0; i < 12; i++) begin
      sclkPosEdge = 1'($urandom_range(0, 1));
      tick();
    end
    sclkPosEdge = 1'b0;
    chk("rst_outs", n_al + n_sr + n_wr + n_mi + n_fe, 0);
    chk("rst_state", int'(dut.r_state), int'(S_IDLE));
    resetN = 1'b1;
    #1;
    chk("rel_outs", int'({addrLatchEn, srLoadEn, dmWriteEn, misoBufEn, w_fe}), 0);
    tick();
    chk("rel_hdr", int'(dut.r_state), int'(S_GET_HDR));
    end_frame();

    // read frame
    clr_cnt();
    start();
    hdr(1'b1);
    pulses(DATA_BITS_DEF - 1);
    chk("rd_mi_7", int'(misoBufEn), 1);
    sclkPosEdge = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    chk("rd_mi_done", int'(misoBufEn), 0);
    chk("rd_state", int'(dut.r_state), int'(S_DONE));
    tick();
    chk("rd_al_cnt", n_al, 1);
    chk("rd_sr_cnt", n_sr, 1);
    chk("rd_wr_cnt", n_wr, 0);
    end_frame();

    // write frame
    clr_cnt();
    start();
    hdr(1'b0);
    pulses(DATA_BITS_DEF - 1);
    chk("wr_none_yet", n_wr, 0);
    sclkPosEdge = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    chk("wr_we", int'(dmWriteEn), 1);
    tick();
    chk("wr_we_low", int'(dmWriteEn), 0);
    chk("wr_done", int'(dut.r_state), int'(S_DONE));
    chk("wr_we_cnt", n_wr, 1);
    chk("wr_sr_cnt", n_sr, 0);
    chk("wr_mi_cnt", n_mi, 0);

    // extra edges in DONE
    clr_cnt();
    pulses(20);
    chk("done_outs", n_al + n_sr + n_wr + n_mi, 0);
    chk("done_stay", int'(dut.r_state), int'(S_DONE));
    end_frame();
    chk("done_fe", n_fe, 0);

    // abort after 11 pulses
    clr_cnt();
    start();
    hdr(1'b0);
    pulses(3);
    csN = 1'b1;
    tick();
    chk("ab_idle", int'(dut.r_state), int'(S_IDLE));
    tick(); tick();
    chk("ab_wr", n_wr, 0);
`ifdef SPI_FSM_FRAME_ERR_EN
    chk("ab_fe", n_fe, 1);
`endif

    // race: csN rises with final data edge
    clr_cnt();
    start();
    hdr(1'b0);
    pulses(DATA_BITS_DEF - 1);
    sclkPosEdge = 1'b1;
    csN = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    chk("race_idle", int'(dut.r_state), int'(S_IDLE));
    tick(); tick();
    chk("race_wr", n_wr, 0);

    // second full read frame, then async reset mid-shift
    clr_cnt();
    start();
    hdr(1'b1);
    pulses(DATA_BITS_DEF);
    chk("rd2_done", int'(dut.r_state), int'(S_DONE));
    chk("rd2_fe", n_fe, 0);
    end_frame();
    start();
    hdr(1'b1);
    pulses(2);
    chk("rs_mi_pre", int'(misoBufEn), 1);
    #2 resetN = 1'b0;
    #1;
    chk("rs_mi_async", int'(misoBufEn), 0);
    clr_cnt();
    tick();
    csN = 1'b1;
    resetN = 1'b1;
    tick(); tick();
    chk("rs_outs", n_al + n_sr + n_wr + n_mi + n_fe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
